// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 fetch stage: fetch FSM states, the
// instruction width in bytes and the word written into a cleared IF/ID slot.
package legv8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALTED
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // Architectural NOP, parked in IF/ID whenever the slot is invalidated so a
  // stale word never looks like a live instruction downstream.
  localparam logic [31:0] NOP_INSTR = 32'hD503_201F;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: PC, instruction word and valid flag.
// clear has priority over load; with neither asserted the contents hold.
module if_id_register
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [63:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [63:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [63:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  // Capture, invalidate or hold the fetched instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 64'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: owns the PC, addresses instruction memory and fills
// the IF/ID register. Handles redirect, flush, stall, end-of-memory halt
// and sticky faulting on illegal redirect targets.
module instruction_fetch
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] instructionAddress,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES) - 64'(INSTR_BYTES);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q, count_d;
  logic         ifid_load, ifid_clear;
  logic         target_ok;
  logic         at_end;
  logic [63:0]  pc_plus4;

  assign target_ok = (branch_target[1:0] == 2'b00) && (branch_target <= LAST_PC);
  assign at_end    = (pc_q == LAST_PC);
  assign pc_plus4  = pc_q + 64'(INSTR_BYTES);

  // State, PC, fault and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // Next-state, next-PC and IF/ID control; redirect > flush > stall > fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    count_d    = count_q;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ifid_clear = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        if (branch_taken) begin
          ifid_clear = 1'b1;
          if (target_ok) begin
            pc_d = branch_target;
          end else begin
            fault_d = 1'b1;
            state_d = ST_HALTED;
          end
        end else if (flush) begin
          ifid_clear = 1'b1;
          if (at_end) state_d = ST_HALTED;
          else        pc_d    = pc_plus4;
        end else if (!stall) begin
          ifid_load = 1'b1;
          count_d   = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
          if (at_end) state_d = ST_HALTED;
          else        pc_d    = pc_plus4;
        end
      end
      ST_HALTED: begin
        // Also drops the last word captured on the entry edge.
        ifid_clear = 1'b1;
        if (branch_taken && target_ok && !fault_q) begin
          pc_d    = branch_target;
          state_d = ST_FETCH;
        end
      end
      default: begin
        ifid_clear = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase
  end

  if_id_register u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .clear_i (ifid_clear),
    .pc_i    (pc_q),
    .instr_i (instruction),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instruction),
    .valid_o (if_id_valid)
  );

  assign instructionAddress = pc_q;
  assign halted             = (state_q == ST_HALTED);
  assign fault              = fault_q;
  assign fetch_count        = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random
// stall/flush/redirect traffic, compared against a behavioural model.
module tb_instruction_fetch;

  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
  localparam logic [63:0] LAST      = 64'(MEM_BYTES) - 64'd4;

  logic        clk;
  logic        rst_n;
  logic [63:0] instructionAddress;
  logic [31:0] instruction;
  logic        stall, flush, branch_taken;
  logic [63:0] branch_target;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid, halted, fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [MEM_WORDS];

  int n_vec = 0;
  int n_err = 0;

  // reference model
  bit          m_idle, m_halted, m_fault, m_valid;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ifinstr, m_count;

  instruction_fetch #(.RESET_PC(64'd0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instructionAddress (instructionAddress),
    .instruction        (instruction),
    .stall              (stall),
    .flush              (flush),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .if_id_pc           (if_id_pc),
    .if_id_instruction  (if_id_instruction),
    .if_id_valid        (if_id_valid),
    .halted             (halted),
    .fault              (fault),
    .fetch_count        (fetch_count)
  );

  assign instruction = (instructionAddress < 64'(MEM_BYTES)) ?
                       mem[instructionAddress[11:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit legal(input logic [63:0] t);
    return (t % 64'd4 == 64'd0) && (t <= LAST);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_halted = 0; m_fault = 0; m_valid = 0;
    m_pc = 64'd0; m_ifpc = 64'd0; m_ifinstr = 32'd0; m_count = 32'd0;
  endtask

  // One clock edge of the specified fetch behaviour.
  task automatic model_step(input bit s, input bit f, input bit b, input logic [63:0] t);
    if (m_idle) begin
      m_idle = 0; m_valid = 0;
    end else if (m_halted) begin
      m_valid = 0;
      if (b && legal(t) && !m_fault) begin m_pc = t; m_halted = 0; end
    end else if (b) begin
      m_valid = 0;
      if (legal(t)) m_pc = t;
      else begin m_fault = 1; m_halted = 1; end
    end else if (f) begin
      m_valid = 0;
      if (m_pc == LAST) m_halted = 1; else m_pc = m_pc + 4;
    end else if (!s) begin
      m_ifpc = m_pc; m_ifinstr = mem[m_pc / 4]; m_valid = 1;
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      if (m_pc == LAST) m_halted = 1; else m_pc = m_pc + 4;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_pc"}, instructionAddress, m_pc);
    chk({ph, "_valid"}, 64'(if_id_valid), 64'(m_valid));
    chk({ph, "_halted"}, 64'(halted), 64'(m_halted));
    chk({ph, "_fault"}, 64'(fault), 64'(m_fault));
    chk({ph, "_count"}, 64'(fetch_count), 64'(m_count));
    if (m_valid) begin
      chk({ph, "_ifpc"}, if_id_pc, m_ifpc);
      chk({ph, "_ifinstr"}, 64'(if_id_instruction), 64'(m_ifinstr));
    end
  endtask

  task automatic cycle(input string ph, input bit s, input bit f, input bit b,
                       input logic [63:0] t);
    stall = s; flush = f; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_step(s, f, b, t);
    #1;
    check_all(ph);
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock.
  task automatic do_reset();
    stall = 0; flush = 0; branch_taken = 0; branch_target = 64'd0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("rst");
    chk("rst_ifpc", if_id_pc, 64'd0);
    chk("rst_ifinstr", 64'(if_id_instruction), 64'd0);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rand_target();
    int sel;
    sel = int'($urandom % 16);
    if (sel == 0)      return 64'(($urandom % MEM_WORDS) * 4 + 1 + $urandom % 3);
    else if (sel == 1) return 64'(MEM_BYTES) + 64'(($urandom % 64) * 4);
    else if (sel == 2) return LAST;
    else if (sel == 3) return LAST - 64'd4;
    else               return 64'(($urandom % MEM_WORDS) * 4);
  endfunction

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
    mem[0] = 32'h8B02_0020;
    mem[1] = 32'hB100_2020;

    rst_n = 1'b0; stall = 0; flush = 0; branch_taken = 0; branch_target = 64'd0;
    model_reset();
    #3;
    check_all("por");
    chk("por_ifinstr", 64'(if_id_instruction), 64'd0);
    #4 rst_n = 1'b1;

    // IDLE bubble, then first two words
    cycle("idle", 0, 0, 0, 0);
    chk("idle_nocap", 64'(if_id_valid), 64'd0);
    cycle("cap0", 0, 0, 0, 0);
    chk("tp_word0", 64'(if_id_instruction), 64'h8B02_0020);
    chk("tp_pc0", if_id_pc, 64'd0);
    cycle("cap1", 0, 0, 0, 0);
    chk("tp_word1", 64'(if_id_instruction), 64'hB100_2020);
    chk("tp_count2", 64'(fetch_count), 64'd2);

    // stall at pc=8, then resume
    for (int i = 0; i < 3; i++) cycle("stall", 1, 0, 0, 0);
    cycle("resume", 0, 0, 0, 0);
    chk("resume_pc8", if_id_pc, 64'd8);

    // branch beats stall: one bubble then target
    cycle("brst", 1, 0, 1, 64'h20);
    cycle("brcap", 0, 0, 0, 0);
    chk("br_pc20", if_id_pc, 64'h20);
    cycle("run", 0, 0, 0, 0);

    // flush, also combined with stall
    cycle("flush", 0, 1, 0, 0);
    cycle("flst", 1, 1, 0, 0);
    cycle("run", 0, 0, 0, 0);

    // misaligned target -> sticky fault, later branch ignored
    cycle("bad", 0, 0, 1, 64'h22);
    cycle("ign", 0, 0, 1, 64'h40);
    cycle("ign", 0, 0, 1, 64'h0);
    chk("fault_sticky", 64'(fault), 64'd1);
    do_reset();

    // end of memory halt, then resume with a legal branch
    cycle("idle2", 0, 0, 0, 0);
    cycle("brend", 0, 0, 1, LAST);
    cycle("last", 0, 0, 0, 0);
    chk("last_word", 64'(if_id_instruction), 64'(mem[MEM_WORDS-1]));
    cycle("hclr", 0, 0, 0, 0);
    cycle("hold", 1, 0, 0, 0);
    cycle("back", 0, 0, 1, 64'd0);
    cycle("run", 0, 0, 0, 0);
    cycle("run", 0, 0, 0, 0);

    // flush at the last word also halts
    cycle("brend2", 0, 0, 1, LAST);
    cycle("flend", 0, 1, 0, 0);
    cycle("run", 0, 0, 0, 0);

    // mid-stream asynchronous reset
    do_reset();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ((m_fault && ($urandom % 4 == 0)) || ($urandom % 150 == 0)) do_reset();
      else cycle("rnd", ($urandom % 4) == 0, ($urandom % 8) == 0,
                 ($urandom % 10) == 0, rand_target());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the LEGv8 pipeline. Owns the 64-bit program counter, drives the byte address into the instruction memory, and registers the returned 32-bit little-endian instruction word into the IF/ID pipeline register for the instruction decoder. Handles sequential advance (PC+4), branch redirect from later stages, stall, flush, end-of-memory halt, and misaligned or out-of-range target faults.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded on reset
- MEM_BYTES, 4096, instruction memory size in bytes; legal fetch addresses are 0..MEM_BYTES-4, word aligned

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instructionAddress  out  64  byte address to instruction memory; equals pc register, never combinationally altered
- instruction  in  32  word returned by instruction memory for instructionAddress (combinational, same cycle)
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  invalidate IF/ID contents at next edge
- branch_taken  in  1  redirect request from execute stage
- branch_target  in  64  redirect byte address
- if_id_pc  out  64  PC of registered instruction
- if_id_instruction  out  32  registered instruction word
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch has stopped (state HALTED)
- fault  out  1  sticky: illegal redirect target received
- fetch_count  out  32  number of instructions captured valid, saturates at 2^32-1

## Operation
- States: IDLE, FETCH, HALTED.
- Reset (rst_n=0, asynchronous): pc=RESET_PC, if_id_pc=0, if_id_instruction=0, if_id_valid=0, fetch_count=0, halted=0, fault=0, state=IDLE.
- IDLE: one bubble cycle after reset release; no capture, pc held, if_id_valid=0; → FETCH unconditionally.
- FETCH, per edge, priority highest first:
  1. branch_taken: target legal (target[1:0]==0 and target ≤ MEM_BYTES-4) → pc=target, if_id_valid=0. Illegal → fault=1, if_id_valid=0, pc held, → HALTED.
  2. flush (without branch): if_id_valid=0, pc=pc+4 (or halt rule below).
  3. stall: pc, if_id_* and fetch_count all hold.
  4. normal: if_id_pc=pc, if_id_instruction=instruction, if_id_valid=1, fetch_count+1; pc=pc+4, except pc==MEM_BYTES-4 → pc held, → HALTED after capturing that last word.
- HALTED: if_id_valid=0 (cleared on entry edge unless the entry edge was the last-word capture, in which case cleared on the following edge), pc held, halted=1. Legal branch_taken with fault==0 → pc=target, → FETCH. With fault==1, only reset exits.
- stall has no effect on branch_taken or flush; simultaneous stall+branch → branch wins.
- PC arithmetic is 64-bit unsigned; wrap cannot occur because of the end-of-memory rule.

## Timing
- Instruction at address A appears on if_id_* one edge after pc==A (one-cycle fetch latency, memory read combinational).
- First valid IF/ID: second rising edge after rst_n deasserts (IDLE bubble, then capture of RESET_PC).
- Redirect: branch_taken sampled at edge N → pc=target after N; target's word valid on if_id after N+1. Exactly one bubble.
- halted and fault are registered; asserted the cycle after the causing edge.
- rst_n assertion mid-operation clears everything immediately, independent of clk.

## Structure
- Shared package (legv8_pkg): fetch state enum (IDLE, FETCH, HALTED), INSTR_BYTES=4, NOP encoding for cleared if_id_instruction.
- One sub-module: if_id_register (pc, instruction, valid with load/hold/clear controls); PC/state logic stays in instruction_fetch.

## Test plan
- Reset release, memory holds 0x8B020020 at 0, 0xB10020 20 at 4 → if_id_instruction=0x8B020020, if_id_pc=0 at 2nd edge, then 0xB1002020, pc=4 at 3rd; fetch_count=2.
- stall high 3 cycles at pc=8 → pc, if_id_* and fetch_count unchanged; resume captures pc=8.
- branch_taken with target 0x20 while stall=1 → one bubble (if_id_valid=0), then if_id_pc=0x20.
- branch_target=0x22 → fault=1, halted=1, pc held; later legal branch ignored until reset.
- Branch to MEM_BYTES-4=4092 → word at 4092 captured, then halted=1, if_id_valid=0; legal branch to 0 resumes fetch.
- rst_n pulsed low mid-stream between edges → all outputs zero immediately, pc=RESET_PC.
